// File: rtl/kairo_dbg_regacc.sv
// Debug register-access engine: one command at a time into the core register file while halted.
// Optional auto-increment addressing is enabled with KAIRO_DBG_REGACC_AUTOINC_EN.
module kairo_dbg_regacc #(
    parameter int RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CORE_HALTED,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WR,
    input  logic [4:0]  CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
`ifdef KAIRO_DBG_REGACC_AUTOINC_EN
    input  logic        CMD_INC,
`endif
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        AR_EN,
    output logic        AR_WR,
    output logic [4:0]  AR_AD,
    output logic [31:0] AR_DI,
    input  logic [31:0] AR_DO,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t      state_q, state_d;
    logic        wr_q;
    logic        err_q;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  cnt_q;
    logic        accept;
    logic        capture;
    logic        done;
    logic [4:0]  eff_addr;

`ifdef KAIRO_DBG_REGACC_AUTOINC_EN
    logic [4:0] ptr_q;

    assign eff_addr = CMD_INC ? ptr_q : CMD_ADDR;

    // Pointer advances only on successful completions so a rejected command can be retried.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q <= 5'd0;
        end else if (accept && !CMD_INC) begin
            ptr_q <= CMD_ADDR;
        end else if (done && !err_q) begin
            ptr_q <= ptr_q + 5'd1;
        end
    end
`else
    assign eff_addr = CMD_ADDR;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Access-port outputs are decoded from state so reset removes AR_EN without waiting for a clock.
    always_comb begin
        state_d   = state_q;
        CMD_READY = 1'b0;
        RSP_VALID = 1'b0;
        AR_EN     = 1'b0;
        AR_WR     = 1'b0;
        AR_AD     = 5'd0;
        AR_DI     = 32'd0;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) begin
                    accept  = 1'b1;
                    state_d = CORE_HALTED ? ACC : RESP;
                end
            end
            ACC: begin
                AR_EN = 1'b1;
                AR_WR = wr_q;
                AR_AD = addr_q;
                AR_DI = wr_q ? wdata_q : 32'd0;
                if (wr_q) begin
                    state_d = RESP;
                end else if (RD_LAT == 1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                AR_EN = 1'b1;
                AR_AD = addr_q;
                if (cnt_q == 2'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // x0 is masked here because the register file only masks it on the core-side port.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 5'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            if (accept) begin
                wr_q    <= CMD_WR;
                err_q   <= !CORE_HALTED;
                addr_q  <= eff_addr;
                wdata_q <= CMD_WDATA;
                rdata_q <= 32'd0;
                cnt_q   <= WAIT_INIT;
            end
            if (state_q == WAIT && cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (capture) begin
                rdata_q <= (addr_q == 5'd0) ? 32'd0 : AR_DO;
            end
        end
    end

    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_kairo_dbg_regacc.sv
// Directed bench for kairo_dbg_regacc (RD_LAT=3) with a simple register-file model.
// Define KAIRO_DBG_REGACC_AUTOINC_EN to also exercise auto-increment addressing.
module tb_kairo_dbg_regacc;

    localparam int RD_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        core_halted;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
`ifdef KAIRO_DBG_REGACC_AUTOINC_EN
    logic        cmd_inc;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ar_en;
    logic        ar_wr;
    logic [4:0]  ar_ad;
    logic [31:0] ar_di;
    logic [31:0] ar_do;
    logic        busy;
    logic        force_ones;

    logic [31:0] reg_mem [32];

    int          check_count;
    int          error_count;
    int          en_cycles;
    int          wr_cycles;
    int          rsp_at;
    int          turnaround;
    logic [4:0]  seen_ad;
    logic [31:0] seen_di;

    kairo_dbg_regacc #(.RD_LAT(RD_LAT)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .CORE_HALTED(core_halted),
        .CMD_VALID  (cmd_valid),
        .CMD_READY  (cmd_ready),
        .CMD_WR     (cmd_wr),
        .CMD_ADDR   (cmd_addr),
        .CMD_WDATA  (cmd_wdata),
`ifdef KAIRO_DBG_REGACC_AUTOINC_EN
        .CMD_INC    (cmd_inc),
`endif
        .RSP_VALID  (rsp_valid),
        .RSP_READY  (rsp_ready),
        .RSP_RDATA  (rsp_rdata),
        .RSP_ERR    (rsp_err),
        .AR_EN      (ar_en),
        .AR_WR      (ar_wr),
        .AR_AD      (ar_ad),
        .AR_DI      (ar_di),
        .AR_DO      (ar_do),
        .BUSY       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: read data follows the address while enabled; force_ones mimics a raw x0 read.
    always_comb begin
        ar_do = 32'd0;
        if (ar_en) ar_do = force_ones ? 32'hFFFF_FFFF : reg_mem[ar_ad];
    end

    always @(posedge clk) begin
        if (ar_en && ar_wr) reg_mem[ar_ad] <= ar_di;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One command; hold>0 keeps RSP_READY low that many extra cycles; drop_halt_at>0 drops CORE_HALTED mid-access.
    task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int hold, input int drop_halt_at);
        int cnt;
        en_cycles = 0;
        wr_cycles = 0;
        seen_ad   = 5'd0;
        seen_di   = 32'd0;
        @(negedge clk);
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        rsp_ready = (hold == 0);
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) cmd_valid = 1'b0;
            if (cnt == drop_halt_at) core_halted = 1'b0;
            if (ar_en) begin
                en_cycles++;
                seen_ad = ar_ad;
                if (ar_wr) begin
                    wr_cycles++;
                    seen_di = ar_di;
                end
            end
            if (rsp_valid) break;
        end
        rsp_at = cnt;
        checkOutput("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cnt++;
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rdata", rsp_rdata, exp_rdata);
            checkOutput("hold_err", 32'(rsp_err), 32'(exp_err));
            checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (cmd_ready) break;
        end
        turnaround = cnt;
        checkOutput("back_to_idle", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        check_count = 0;
        error_count = 0;
        rst_n       = 1'b0;
        core_halted = 1'b1;
        cmd_valid   = 1'b0;
        cmd_wr      = 1'b0;
        cmd_addr    = 5'd0;
        cmd_wdata   = 32'd0;
        rsp_ready   = 1'b1;
        force_ones  = 1'b0;
`ifdef KAIRO_DBG_REGACC_AUTOINC_EN
        cmd_inc     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_ar_en", 32'(ar_en), 32'd0);
        checkOutput("rst_ar_ad", 32'(ar_ad), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

        $display("[TB] halted write addr 5");
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, 0);
        checkOutput("wr_en_cycles", en_cycles, 1);
        checkOutput("wr_wr_cycles", wr_cycles, 1);
        checkOutput("wr_ar_ad", 32'(seen_ad), 32'd5);
        checkOutput("wr_ar_di", seen_di, 32'hDEAD_BEEF);
        checkOutput("wr_rsp_at", rsp_at, 2);
        checkOutput("wr_turnaround", turnaround, 3);
        checkOutput("wr_mem5", reg_mem[5], 32'hDEAD_BEEF);

        $display("[TB] halted readback addr 5");
        applyStimulus(1'b0, 5'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 0);
        checkOutput("rd_en_cycles", en_cycles, 3);
        checkOutput("rd_wr_cycles", wr_cycles, 0);
        checkOutput("rd_ar_ad", 32'(seen_ad), 32'd5);
        checkOutput("rd_rsp_at", rsp_at, 4);
        checkOutput("rd_turnaround", turnaround, 5);

        $display("[TB] read addr 7 with RSP_READY held low");
        applyStimulus(1'b1, 5'd7, 32'h1234_5678, 32'd0, 1'b0, 0, 0);
        applyStimulus(1'b0, 5'd7, 32'd0, 32'h1234_5678, 1'b0, 5, 0);
        checkOutput("rd7_en_cycles", en_cycles, 3);
        checkOutput("rd7_rsp_at", rsp_at, 4);

        $display("[TB] commands while core running");
        core_halted = 1'b0;
        applyStimulus(1'b1, 5'd9, 32'hA5A5_A5A5, 32'd0, 1'b1, 0, 0);
        checkOutput("err_wr_en_cycles", en_cycles, 0);
        checkOutput("err_wr_rsp_at", rsp_at, 1);
        applyStimulus(1'b0, 5'd5, 32'd0, 32'd0, 1'b1, 0, 0);
        checkOutput("err_rd_en_cycles", en_cycles, 0);
        checkOutput("err_mem5_intact", reg_mem[5], 32'hDEAD_BEEF);
        core_halted = 1'b1;

        $display("[TB] x0 masking");
        force_ones = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 0, 0);
        checkOutput("x0_en_cycles", en_cycles, 3);
        applyStimulus(1'b0, 5'd3, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 0);
        force_ones = 1'b0;

        $display("[TB] halt dropped during access");
        applyStimulus(1'b0, 5'd7, 32'd0, 32'h1234_5678, 1'b0, 0, 1);
        checkOutput("drop_en_cycles", en_cycles, 3);
        core_halted = 1'b1;

        $display("[TB] reset during WAIT");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 5'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("acc_ar_en", 32'(ar_en), 32'd1);
        @(negedge clk);
        checkOutput("wait_ar_en", 32'(ar_en), 32'd1);
        checkOutput("wait_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_ar_en", 32'(ar_en), 32'd0);
        checkOutput("async_ar_ad", 32'(ar_ad), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b0, 5'd7, 32'd0, 32'h1234_5678, 1'b0, 0, 0);

`ifdef KAIRO_DBG_REGACC_AUTOINC_EN
        $display("[TB] auto-increment wrap");
        cmd_inc = 1'b0;
        applyStimulus(1'b1, 5'd30, 32'h0000_0030, 32'd0, 1'b0, 0, 0);
        checkOutput("inc_ad_first", 32'(seen_ad), 32'd30);
        cmd_inc = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'h0000_0031, 32'd0, 1'b0, 0, 0);
        checkOutput("inc_ad_second", 32'(seen_ad), 32'd31);
        applyStimulus(1'b1, 5'd3, 32'h0000_0000, 32'd0, 1'b0, 0, 0);
        checkOutput("inc_ad_wrap", 32'(seen_ad), 32'd0);
        cmd_inc = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
